// File: rtl/mem_access_unit.sv
// Load/store sequencer: accepts one memory operation at a time, issues a
// single-cycle cache request, then completes on a hit, on a later grant,
// or on timeout with an error. All outputs are registered.
module mem_access_unit #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] address_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [RES_W-1:0]  result,
   output logic              req_valid,
   output logic              req_we,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              rsp_hit,
   input  logic              rsp_gnt,
   input  logic [DATA_W-1:0] rsp_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Timer only has to reach TIMEOUT-1; keep at least one bit when disabled.
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : {TMR_W{1'b0}};
   localparam bit TMO_EN = (TIMEOUT != 0);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [TMR_W-1:0]   timer_r;
   logic               is_store_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [DATA_W-1:0]  wdata_r;

   logic               tmo_s;
   logic               sel_store_s;
   logic [ADDR_W-1:0]  sel_addr_s;
   logic [DATA_W-1:0]  sel_data_s;

   logic               busy_nxt_s;
   logic               done_nxt_s;
   logic               error_nxt_s;
   logic [RES_W-1:0]   result_nxt_s;
   logic               req_valid_nxt_s;
   logic               req_we_nxt_s;
   logic [ADDR_W-1:0]  req_addr_nxt_s;
   logic [DATA_W-1:0]  req_wdata_nxt_s;

   // Completion value: stores report 1, loads report zero-extended read data.
   function automatic logic [RES_W-1:0] completion_value(input logic store,
                                                         input logic [DATA_W-1:0] rdata);
      if (store) begin
         completion_value = RES_W'(1);
      end else begin
         completion_value = RES_W'(rdata);
      end
   endfunction

   // Timeout detection and selection of the operation operands (live inputs on accept).
   always_comb begin
      tmo_s = 1'b0;
      if (TMO_EN && (timer_r == TMR_LAST)) begin
         tmo_s = 1'b1;
      end else begin
         tmo_s = 1'b0;
      end
      if (state_r == ST_IDLE) begin
         sel_store_s = is_store;
         sel_addr_s  = address_in;
         sel_data_s  = data_in;
      end else begin
         sel_store_s = is_store_r;
         sel_addr_s  = addr_r;
         sel_data_s  = wdata_r;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; grant takes priority over timeout in the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_REQ;
            else       state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (rsp_hit) state_nxt_s = ST_DONE;
            else         state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (rsp_gnt)    state_nxt_s = ST_DONE;
            else if (tmo_s) state_nxt_s = ST_DONE;
            else            state_nxt_s = ST_WAIT;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: next-cycle output values derived from the next state.
   always_comb begin
      busy_nxt_s      = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_WAIT);
      done_nxt_s      = (state_nxt_s == ST_DONE);
      req_valid_nxt_s = (state_nxt_s == ST_REQ);
      if (busy_nxt_s) begin
         req_addr_nxt_s = sel_addr_s;
         req_we_nxt_s   = sel_store_s;
         if (sel_store_s) begin
            req_wdata_nxt_s = sel_data_s;
         end else begin
            req_wdata_nxt_s = {DATA_W{1'b0}};
         end
      end else begin
         req_addr_nxt_s  = {ADDR_W{1'b0}};
         req_we_nxt_s    = 1'b0;
         req_wdata_nxt_s = {DATA_W{1'b0}};
      end

      error_nxt_s  = error;
      result_nxt_s = result;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               error_nxt_s  = 1'b0;
               result_nxt_s = {RES_W{1'b0}};
            end else begin
               error_nxt_s  = error;
               result_nxt_s = result;
            end
         end
         ST_REQ: begin
            if (rsp_hit) begin
               result_nxt_s = completion_value(is_store_r, rsp_rdata);
            end else begin
               result_nxt_s = result;
            end
         end
         ST_WAIT: begin
            if (rsp_gnt) begin
               result_nxt_s = completion_value(is_store_r, rsp_rdata);
            end else if (tmo_s) begin
               error_nxt_s  = 1'b1;
               result_nxt_s = {RES_W{1'b0}};
            end else begin
               result_nxt_s = result;
            end
         end
         default: begin
            error_nxt_s  = error;
            result_nxt_s = result;
         end
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         result    <= {RES_W{1'b0}};
         req_valid <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= {ADDR_W{1'b0}};
         req_wdata <= {DATA_W{1'b0}};
      end else begin
         busy      <= busy_nxt_s;
         done      <= done_nxt_s;
         error     <= error_nxt_s;
         result    <= result_nxt_s;
         req_valid <= req_valid_nxt_s;
         req_we    <= req_we_nxt_s;
         req_addr  <= req_addr_nxt_s;
         req_wdata <= req_wdata_nxt_s;
      end
   end

   // Operand capture on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_store_r <= 1'b0;
         addr_r     <= {ADDR_W{1'b0}};
         wdata_r    <= {DATA_W{1'b0}};
      end else if ((state_r == ST_IDLE) && start) begin
         is_store_r <= is_store;
         addr_r     <= address_in;
         wdata_r    <= data_in;
      end else begin
         is_store_r <= is_store_r;
         addr_r     <= addr_r;
         wdata_r    <= wdata_r;
      end
   end

   // WAIT-cycle timer: counts while remaining in WAIT, zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r <= {TMR_W{1'b0}};
      end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
         timer_r <= timer_r + TMR_W'(1);
      end else begin
         timer_r <= {TMR_W{1'b0}};
      end
   end

endmodule
